// File: rtl/pipe_addsub.sv
// Segmented-carry pipelined adder/subtractor. Each stage adds one SEG-bit slice
// and hands its carry, the untouched upper operand slices and the finished lower result slices forward.
module pipe_addsub #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);

  localparam int SEG  = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic [WIDTH-1:0]  r_a   [STAGES];
  logic [WIDTH-1:0]  r_b   [STAGES];
  logic [WIDTH-1:0]  r_res [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_v;
  logic              r_ovf;
  logic              r_zero;

  logic [WIDTH-1:0]  w_a      [STAGES];
  logic [WIDTH-1:0]  w_b      [STAGES];
  logic [WIDTH-1:0]  w_res    [STAGES];
  logic [WIDTH-1:0]  w_res_nx [STAGES];
  logic [STAGES-1:0] w_cin;
  logic [STAGES-1:0] w_cout;
  logic [STAGES-1:0] w_v;
  logic              w_advance;
  logic              w_ovf_nx;
  logic              w_zero_nx;

  assign w_advance = !r_v[LAST] || out_ready;
  assign in_ready  = w_advance;
  assign out_valid = r_v[LAST];
  assign out       = r_res[LAST];
  assign carry     = r_c[LAST];
  assign overflow  = r_ovf;
  assign zero      = r_zero;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG:0]       w_sum;
    logic [WIDTH-1:0]   w_seg;
    if (k == 0) begin : g_first
      // Subtraction folds into the first stage: invert b here, inject sub as carry-in.
      assign w_a[k]   = in_a;
      assign w_b[k]   = in_b ^ {WIDTH{in_sub}};
      assign w_res[k] = '0;
      assign w_cin[k] = in_sub;
      assign w_v[k]   = in_valid;
    end else begin : g_next
      assign w_a[k]   = r_a[k-1];
      assign w_b[k]   = r_b[k-1];
      assign w_res[k] = r_res[k-1];
      assign w_cin[k] = r_c[k-1];
      assign w_v[k]   = r_v[k-1];
    end
    assign w_sum = {1'b0, w_a[k][k*SEG +: SEG]} + {1'b0, w_b[k][k*SEG +: SEG]}
                 + (SEG+1)'(w_cin[k]);
    assign w_seg = WIDTH'(w_sum[SEG-1:0]);
    // Slices above k are still zero in the partial result, so OR-ing places slice k.
    assign w_res_nx[k] = w_res[k] | (w_seg << (k*SEG));
    assign w_cout[k]   = w_sum[SEG];
  end

  assign w_ovf_nx  = (w_a[LAST][WIDTH-1] == w_b[LAST][WIDTH-1]) &&
                     (w_res_nx[LAST][WIDTH-1] != w_a[LAST][WIDTH-1]);
  assign w_zero_nx = (w_res_nx[LAST] == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v    <= '0;
      r_c    <= '0;
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k]   <= '0;
        r_b[k]   <= '0;
        r_res[k] <= '0;
      end
    end else begin
      if (flush) begin
        r_v <= '0;
      end else if (w_advance) begin
        r_v <= w_v;
      end
      if (w_advance) begin
        r_c    <= w_cout;
        r_ovf  <= w_ovf_nx;
        r_zero <= w_zero_nx;
        for (int k = 0; k < STAGES; k++) begin
          r_a[k]   <= w_a[k];
          r_b[k]   <= w_b[k];
          r_res[k] <= w_res_nx[k];
        end
      end
    end
  end

endmodule

// File: doc/pipe_addsub.md
PIPE_ADDSUB -- requirements
Module: pipe_addsub

Interface
REQ-001 Parameter WIDTH, default 32: operand and result width in bits; legal values 8..64.
REQ-002 Parameter STAGES, default 2: number of pipeline stages and carry-chain segments; legal values 1..4; WIDTH SHALL be divisible by STAGES.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst, input, 1: reset, asynchronous and active-high.
REQ-005 Port flush, input, 1: synchronous clear of all in-flight operations.
REQ-006 Port in_valid, input, 1: operands are presented this cycle.
REQ-007 Port in_ready, output, 1: the block accepts the operands this cycle.
REQ-008 Port in_a, input, WIDTH: first operand.
REQ-009 Port in_b, input, WIDTH: second operand.
REQ-010 Port in_sub, input, 1: operation select; 0 = a+b, 1 = a-b.
REQ-011 Port out_valid, output, 1: result is valid.
REQ-012 Port out_ready, input, 1: downstream consumes the result this cycle.
REQ-013 Port out, output, WIDTH: result, modulo 2^WIDTH.
REQ-014 Port carry, output, 1: carry out of the MSB; for subtraction, 1 means no borrow.
REQ-015 Port overflow, output, 1: signed two's-complement overflow.
REQ-016 Port zero, output, 1: out equals 0.

Function
REQ-017 The block SHALL compute a + (b XOR {WIDTH{sub}}) + sub.
REQ-018 The operands SHALL be split into STAGES segments of SEG = WIDTH/STAGES bits, LSB segment first.
- Stage k SHALL add segment k using the registered carry from stage k-1.
- Stage k SHALL carry the not-yet-added upper operand segments and the completed lower result segments forward in registers.
REQ-019 A transfer in SHALL occur when in_valid && in_ready; a transfer out SHALL occur when out_valid && out_ready.
REQ-020 Latency SHALL be exactly STAGES cycles from an accepted input to out_valid, with no stall.
REQ-021 Stall rule:
- advance = !out_valid || out_ready.
- in_ready SHALL equal advance.
- When advance = 0, every stage register, valid bit and output SHALL hold.
REQ-022 Throughput SHALL be one operation per cycle while out_ready = 1; no bubble SHALL be inserted.
REQ-023 A per-stage valid bit SHALL travel with the data.
- Bubbles (in_valid = 0) SHALL propagate as invalid stages.
- out_valid SHALL be the last stage's valid bit.
REQ-024 When an operation leaves the last stage:
- carry SHALL be the final segment carry-out.
- overflow SHALL be (a[MSB] == b'[MSB]) && (out[MSB] != a[MSB]), where b' is the post-inversion b.
- zero SHALL be (out == 0).
REQ-025 out, carry, overflow and zero SHALL be registered and SHALL remain stable while out_valid = 1 and out_ready = 0.
REQ-026 flush = 1 SHALL clear all valid bits on the next edge.
- flush SHALL take priority over advance and over a simultaneous input transfer.
- The input transfer during a flush cycle SHALL be discarded.
- in_ready SHALL still follow REQ-021.
REQ-027 Data values carried by invalid stages are don't-care, but they SHALL NOT affect any valid result.
REQ-028 With STAGES = 1, the block SHALL behave as a single registered adder with latency 1.

Reset
REQ-029 While rst = 1, all stage valid bits and out_valid SHALL be 0 immediately, without waiting for a clock edge.
REQ-030 Reset values: out = 0, carry = 0, overflow = 0, zero = 0, in_ready = 1 (following REQ-021 from out_valid = 0).
REQ-031 Operations in flight when rst asserts SHALL be lost.
REQ-032 The first input accepted after rst deasserts SHALL appear after exactly STAGES cycles.

Verification (WIDTH = 32, STAGES = 2 unless noted)
REQ-033 Input a = 0x0000FFFF, b = 0x00000001, sub = 0 -> after 2 cycles: out = 0x00010000, carry = 0, overflow = 0, zero = 0. Checks the cross-segment carry.
REQ-034 Input a = 0x7FFFFFFF, b = 1, sub = 0 -> out = 0x80000000, overflow = 1, carry = 0. Then input a = 5, b = 5, sub = 1 -> out = 0, zero = 1, carry = 1.
REQ-035 Input a = 0, b = 1, sub = 1 -> out = 0xFFFFFFFF, carry = 0, overflow = 0.
REQ-036 Stream 8 back-to-back operations with out_ready toggling 1,0,0,1 -> results arrive in order with none lost or duplicated, outputs hold during stalls, and in_ready = 0 exactly when out_valid = 1 and out_ready = 0.
REQ-037 Accept 2 operations, then assert rst asynchronously mid-cycle -> out_valid falls immediately. Separately, assert flush with in_valid = 1 -> no out_valid in the next 2 cycles.
REQ-038 Random regression for STAGES in {1, 3, 4} (WIDTH = 24 for STAGES = 3) against a reference model, checking out, carry, overflow, zero and latency.
